lcd_text_sequencer: RTL and testbench

Upstream feeder for the LCD driver: holds a two-line character frame buffer written by the host and streams it to the driver as a byte sequence. Each frame is a DDRAM set-address command for line 1, the line-1 characters, a set-address command for line 2, then the line-2 characters. It replaces the ROM-plus-pointer arrangement at the top level with a writable buffer and an explicit valid/ready byte handshake.

---
 rtl/lcd_text_sequencer_if.sv | 29 ++
 rtl/lcd_text_sequencer.sv | 150 +++++++++++++++
 tb/tb_lcd_text_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_sequencer_if.sv
// Host-side bus of the LCD text sequencer: frame-buffer write port, frame control,
// and the valid/ready byte stream toward the LCD driver.
interface lcd_text_sequencer_if #(
  parameter int unsigned LINE_LEN = 16
);
  localparam int unsigned AW = (2 * LINE_LEN > 1) ? $clog2(2 * LINE_LEN) : 1;

  logic          start;
  logic          auto;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          out_valid;
  logic          out_rs;
  logic [7:0]    out_data;
  logic          out_ready;
  logic          busy;
  logic          frame_done;

  modport master (
    output start, auto, wr_en, wr_addr, wr_data, out_ready,
    input  out_valid, out_rs, out_data, busy, frame_done
  );

  modport slave (
    input  start, auto, wr_en, wr_addr, wr_data, out_ready,
    output out_valid, out_rs, out_data, busy, frame_done
  );
endinterface

// File: rtl/lcd_text_sequencer.sv
// Two-line writable character frame buffer streamed to the LCD driver as
// set-address command, line-1 characters, set-address command, line-2 characters.
module lcd_text_sequencer #(
  parameter int unsigned LINE_LEN   = 16,
  parameter logic [7:0]  LINE2_ADDR = 8'h40
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  lcd_text_sequencer_if.slave bus
);
  localparam int            DEPTH     = 2 * LINE_LEN;
  localparam int unsigned   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   IW        = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [7:0]    CMD_LINE1 = 8'h80;
  localparam logic [7:0]    CMD_LINE2 = 8'h80 | LINE2_ADDR;
  localparam logic [7:0]    BLANK     = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR1 = 3'd1,
    S_LINE1 = 3'd2,
    S_ADDR2 = 3'd3,
    S_LINE2 = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic          r_valid;
  logic          r_rs;
  logic [7:0]    r_data;
  logic          r_busy;
  logic          r_frame_done;
  logic [7:0]    r_buf [DEPTH];

  logic          w_xfer;
  logic          w_last;
  logic          w_wr_ok;
  logic [IW-1:0] w_idx_nxt;
  logic [AW-1:0] w_rd_l1;
  logic [AW-1:0] w_rd_l2;

  assign w_xfer    = r_valid & bus.out_ready;
  assign w_last    = (r_idx == IW'(LINE_LEN - 1));
  assign w_idx_nxt = r_idx + IW'(1);
  assign w_rd_l1   = AW'(w_idx_nxt);
  assign w_rd_l2   = AW'(LINE_LEN) + AW'(w_idx_nxt);
  // Indices past the buffer only exist when LINE_LEN is not a power of two.
  assign w_wr_ok   = bus.wr_en & ({1'b0, bus.wr_addr} < (AW + 1)'(DEPTH));

  // Frame buffer: single write port, reads only feed the output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= BLANK;
      end
    end else if (w_wr_ok) begin
      r_buf[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Frame sequencer; every output is a register loaded on state transitions.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_valid      <= 1'b0;
      r_rs         <= 1'b0;
      r_data       <= 8'h00;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_ADDR1;
            r_valid <= 1'b1;
            r_rs    <= 1'b0;
            r_data  <= CMD_LINE1;
            r_busy  <= 1'b1;
          end
        end
        S_ADDR1: begin
          if (w_xfer) begin
            r_state <= S_LINE1;
            r_idx   <= '0;
            r_rs    <= 1'b1;
            r_data  <= r_buf[0];
          end
        end
        S_LINE1: begin
          if (w_xfer) begin
            if (w_last) begin
              r_state <= S_ADDR2;
              r_rs    <= 1'b0;
              r_data  <= CMD_LINE2;
            end else begin
              r_idx  <= w_idx_nxt;
              r_data <= r_buf[w_rd_l1];
            end
          end
        end
        S_ADDR2: begin
          if (w_xfer) begin
            r_state <= S_LINE2;
            r_idx   <= '0;
            r_rs    <= 1'b1;
            r_data  <= r_buf[LINE_LEN];
          end
        end
        S_LINE2: begin
          if (w_xfer) begin
            if (w_last) begin
              r_state      <= S_DONE;
              r_valid      <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_idx  <= w_idx_nxt;
              r_data <= r_buf[w_rd_l2];
            end
          end
        end
        S_DONE: begin
          r_frame_done <= 1'b0;
          if (bus.auto) begin
            r_state <= S_ADDR1;
            r_valid <= 1'b1;
            r_rs    <= 1'b0;
            r_data  <= CMD_LINE1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_valid      <= 1'b0;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid  = r_valid;
  assign bus.out_rs     = r_rs;
  assign bus.out_data   = r_data;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Directed testbench for lcd_text_sequencer: frame content, timing, stalls,
// auto-repeat, same-edge write/load and mid-frame reset.
module tb_lcd_text_sequencer;
  logic clk;
  logic rst_n;

  lcd_text_sequencer_if #(.LINE_LEN(16)) bus ();

  lcd_text_sequencer #(.LINE_LEN(16), .LINE2_ADDR(8'h40)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_pass;
  int         n_total;
  logic [7:0] tb_buf   [0:31];
  logic [7:0] exp_data [0:33];
  logic       exp_rs   [0:33];
  logic [7:0] got_data [0:99];
  logic       got_rs   [0:99];
  int         got_n;
  int         fd_cycle;
  int         stall_err;

  task automatic build_expected();
    exp_data[0] = 8'h80;
    exp_rs[0]   = 1'b0;
    exp_data[17] = 8'hC0;
    exp_rs[17]   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_data[1 + i]  = tb_buf[i];
      exp_rs[1 + i]    = 1'b1;
      exp_data[18 + i] = tb_buf[16 + i];
      exp_rs[18 + i]   = 1'b1;
    end
  endtask

  task automatic write_byte(input logic [4:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tb_buf[addr] = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Returns at the falling edge of cycle 1 (start sampled at edge 0).
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_frame(input bit random_ready, input int max_cycles);
    int c;
    logic pv, prs, pr;
    logic [7:0] pd;
    got_n = 0;
    fd_cycle = -1;
    stall_err = 0;
    c = 1;
    pv = 1'b0;
    pr = 1'b1;
    prs = 1'b0;
    pd = 8'h00;
    while (c <= max_cycles && fd_cycle < 0) begin
      if (pv && !pr) begin
        if (bus.out_valid !== 1'b1 || bus.out_data !== pd || bus.out_rs !== prs) stall_err++;
      end
      if (random_ready) bus.out_ready = ($urandom_range(0, 2) != 0);
      else bus.out_ready = 1'b1;
      if (bus.frame_done === 1'b1) fd_cycle = c;
      if (bus.out_valid === 1'b1 && bus.out_ready && got_n < 100) begin
        got_data[got_n] = bus.out_data;
        got_rs[got_n]   = bus.out_rs;
        got_n++;
      end
      pv  = bus.out_valid;
      pd  = bus.out_data;
      prs = bus.out_rs;
      pr  = bus.out_ready;
      @(negedge clk);
      c++;
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.out_rs !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.busy !== 1'b0 || bus.frame_done !== 1'b0)
      $display("FAIL reset_outputs: got v=%b rs=%b d=%h busy=%b fd=%b, expected all zero",
               bus.out_valid, bus.out_rs, bus.out_data, bus.busy, bus.frame_done);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_default_frame();
    int valid_err, busy_err, fd_count, fd_first;
    valid_err = 0; busy_err = 0; fd_count = 0; fd_first = -1; got_n = 0;
    bus.out_ready = 1'b1;
    bus.auto = 1'b0;
    pulse_start();
    for (int c = 1; c <= 40; c++) begin
      if (bus.out_valid !== ((c >= 1 && c <= 34) ? 1'b1 : 1'b0)) valid_err++;
      if (bus.busy !== ((c <= 35) ? 1'b1 : 1'b0)) busy_err++;
      if (bus.frame_done === 1'b1) begin
        fd_count++;
        if (fd_first < 0) fd_first = c;
      end
      if (bus.out_valid === 1'b1 && got_n < 100) begin
        got_data[got_n] = bus.out_data;
        got_rs[got_n]   = bus.out_rs;
        got_n++;
      end
      @(negedge clk);
    end
    n_total++; if (valid_err !== 0) $display("FAIL default_valid_window: got %0d bad cycles, expected 0", valid_err); else n_pass++;
    n_total++; if (busy_err !== 0) $display("FAIL default_busy_window: got %0d bad cycles, expected 0", busy_err); else n_pass++;
    n_total++; if (fd_first !== 35) $display("FAIL default_frame_done_cycle: got %0d, expected 35", fd_first); else n_pass++;
    n_total++; if (fd_count !== 1) $display("FAIL default_frame_done_width: got %0d, expected 1", fd_count); else n_pass++;
    n_total++; if (got_n !== 34) $display("FAIL default_byte_count: got %0d, expected 34", got_n); else n_pass++;
    n_total++; if (got_data[17] !== 8'hC0) $display("FAIL default_line2_cmd: got %h, expected c0", got_data[17]); else n_pass++;
    build_expected();
    for (int i = 0; i < 34; i++) begin
      n_total++;
      if (got_data[i] !== exp_data[i] || got_rs[i] !== exp_rs[i])
        $display("FAIL default_byte[%0d]: got %h/rs%b, expected %h/rs%b", i, got_data[i], got_rs[i], exp_data[i], exp_rs[i]);
      else n_pass++;
    end
  endtask

  task automatic test_hello_world();
    logic [7:0] hello [0:4];
    logic [7:0] world [0:4];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    world = '{8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};
    for (int i = 0; i < 5; i++) write_byte(5'(i), hello[i]);
    for (int i = 0; i < 5; i++) write_byte(5'(16 + i), world[i]);
    pulse_start();
    run_frame(1'b0, 400);
    n_total++; if (fd_cycle !== 35) $display("FAIL hello_frame_done_cycle: got %0d, expected 35", fd_cycle); else n_pass++;
    n_total++; if (got_data[1] !== 8'h48) $display("FAIL hello_first_char: got %h, expected 48", got_data[1]); else n_pass++;
    n_total++; if (got_data[22] !== 8'h44) $display("FAIL hello_last_world_char: got %h, expected 44", got_data[22]); else n_pass++;
    build_expected();
    for (int i = 0; i < 34; i++) begin
      n_total++;
      if (got_data[i] !== exp_data[i] || got_rs[i] !== exp_rs[i])
        $display("FAIL hello_byte[%0d]: got %h/rs%b, expected %h/rs%b", i, got_data[i], got_rs[i], exp_data[i], exp_rs[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stalls();
    pulse_start();
    run_frame(1'b1, 400);
    n_total++; if (stall_err !== 0) $display("FAIL stall_stability: got %0d unstable cycles, expected 0", stall_err); else n_pass++;
    n_total++; if (got_n !== 34) $display("FAIL stall_transfer_count: got %0d, expected 34", got_n); else n_pass++;
    n_total++; if (fd_cycle < 35) $display("FAIL stall_frame_done: got cycle %0d, expected >= 35", fd_cycle); else n_pass++;
    build_expected();
    for (int i = 0; i < 34; i++) begin
      n_total++;
      if (got_data[i] !== exp_data[i] || got_rs[i] !== exp_rs[i])
        $display("FAIL stall_byte[%0d]: got %h/rs%b, expected %h/rs%b", i, got_data[i], got_rs[i], exp_data[i], exp_rs[i]);
      else n_pass++;
    end
  endtask

  task automatic test_auto();
    int fd_list [0:3];
    int fd_n;
    fd_n = 0;
    got_n = 0;
    bus.out_ready = 1'b1;
    bus.auto = 1'b1;
    pulse_start();
    for (int c = 1; c <= 90; c++) begin
      if (c == 40) bus.auto = 1'b0;
      bus.start = (c >= 10 && c <= 12) ? 1'b1 : 1'b0;
      if (bus.frame_done === 1'b1 && fd_n < 4) begin
        fd_list[fd_n] = c;
        fd_n++;
      end
      if (c == 36) begin
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h80 || bus.out_rs !== 1'b0)
          $display("FAIL auto_restart_byte: got v=%b d=%h rs=%b, expected v=1 d=80 rs=0", bus.out_valid, bus.out_data, bus.out_rs);
        else n_pass++;
      end
      if (c == 71) begin
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL auto_idle_after_second: got busy=%b, expected 0", bus.busy); else n_pass++;
      end
      if (bus.out_valid === 1'b1 && got_n < 100) begin
        got_data[got_n] = bus.out_data;
        got_rs[got_n]   = bus.out_rs;
        got_n++;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    n_total++; if (fd_n !== 2) $display("FAIL auto_frame_count: got %0d, expected 2", fd_n); else n_pass++;
    n_total++; if (fd_list[0] !== 35 || fd_list[1] !== 70)
      $display("FAIL auto_frame_done_cycles: got %0d,%0d, expected 35,70", fd_list[0], fd_list[1]); else n_pass++;
    n_total++; if (got_n !== 68) $display("FAIL auto_byte_count: got %0d, expected 68", got_n); else n_pass++;
    build_expected();
    for (int i = 0; i < 68; i++) begin
      n_total++;
      if (got_data[i] !== exp_data[i % 34] || got_rs[i] !== exp_rs[i % 34])
        $display("FAIL auto_byte[%0d]: got %h/rs%b, expected %h/rs%b", i, got_data[i], got_rs[i], exp_data[i % 34], exp_rs[i % 34]);
      else n_pass++;
    end
  endtask

  task automatic test_same_edge_write();
    got_n = 0;
    bus.out_ready = 1'b1;
    pulse_start();
    // buf[3] is loaded at edge 4, when byte 3 (buf[2]) transfers.
    for (int c = 1; c <= 45; c++) begin
      if (c == 4) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd3;
        bus.wr_data = 8'h5A;
      end else begin
        bus.wr_en = 1'b0;
      end
      if (bus.out_valid === 1'b1 && got_n < 100) begin
        got_data[got_n] = bus.out_data;
        got_n++;
      end
      @(negedge clk);
    end
    n_total++; if (got_data[4] !== 8'h4C) $display("FAIL same_edge_old_value: got %h, expected 4c", got_data[4]); else n_pass++;
    tb_buf[3] = 8'h5A;
    pulse_start();
    run_frame(1'b0, 400);
    n_total++; if (got_data[4] !== 8'h5A) $display("FAIL same_edge_new_value: got %h, expected 5a", got_data[4]); else n_pass++;
    build_expected();
    for (int i = 0; i < 34; i++) begin
      n_total++;
      if (got_data[i] !== exp_data[i])
        $display("FAIL same_edge_byte[%0d]: got %h, expected %h", i, got_data[i], exp_data[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int fd_count, valid_count;
    fd_count = 0; valid_count = 0;
    bus.out_ready = 1'b1;
    pulse_start();
    repeat (7) @(negedge clk);
    n_total++; if (bus.out_rs !== 1'b1 || bus.busy !== 1'b1)
      $display("FAIL midreset_in_line1: got rs=%b busy=%b, expected 1 1", bus.out_rs, bus.busy); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.out_rs !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.busy !== 1'b0 || bus.frame_done !== 1'b0)
      $display("FAIL midreset_outputs: got v=%b rs=%b d=%h busy=%b fd=%b, expected all zero",
               bus.out_valid, bus.out_rs, bus.out_data, bus.busy, bus.frame_done);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus.frame_done === 1'b1) fd_count++;
      if (bus.out_valid === 1'b1) valid_count++;
      @(negedge clk);
    end
    n_total++; if (fd_count !== 0) $display("FAIL midreset_no_frame_done: got %0d pulses, expected 0", fd_count); else n_pass++;
    n_total++; if (valid_count !== 0) $display("FAIL midreset_stays_idle: got %0d valid cycles, expected 0", valid_count); else n_pass++;
    for (int i = 0; i < 32; i++) tb_buf[i] = 8'h20;
    pulse_start();
    run_frame(1'b0, 400);
    n_total++; if (got_data[0] !== 8'h80) $display("FAIL midreset_restart_cmd: got %h, expected 80", got_data[0]); else n_pass++;
    build_expected();
    for (int i = 0; i < 34; i++) begin
      n_total++;
      if (got_data[i] !== exp_data[i] || got_rs[i] !== exp_rs[i])
        $display("FAIL midreset_byte[%0d]: got %h/rs%b, expected %h/rs%b", i, got_data[i], got_rs[i], exp_data[i], exp_rs[i]);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    bus.start = 1'b0;
    bus.auto = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = 5'd0;
    bus.wr_data = 8'h00;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) tb_buf[i] = 8'h20;
    test_reset();
    test_default_frame();
    test_hello_world();
    test_stalls();
    test_auto();
    test_same_edge_write();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
